// File: rtl/vector_op_sequencer.sv
// Vector instruction sequencer: latches a decoded vector op and issues one
// element op per lane handshake to the shared scalar ALU, stalling decode meanwhile.
module vector_op_sequencer #(
  parameter int unsigned VLEN  = 8,
  parameter int unsigned IDX_W = $clog2(VLEN),
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [15:0]      control_signals,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             flush,
  output logic             issue_ready,
  output logic             stall,
  output logic             lane_valid,
  input  logic             lane_ready,
  output logic [IDX_W-1:0] lane_idx,
  output logic [3:0]       lane_aluop,
  output logic [REG_W-1:0] lane_rd,
  output logic [REG_W-1:0] lane_rs1,
  output logic [REG_W-1:0] lane_rs2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_ops_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             vec_issue;
  logic             lane_fire;
  logic             ctrl_unused;

  // Only the vector flag and aluOp are consumed here; the rest of the word
  // belongs to the scalar datapath.
  assign ctrl_unused = ^{control_signals[15:10], control_signals[8:4]};

  assign vec_issue = issue_valid & control_signals[9] & ~flush;
  assign lane_fire = lane_valid & lane_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (vec_issue) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (lane_fire) begin
          if (idx == LAST_IDX) state_nxt = DONE;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (flush) idx_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_aluop <= '0;
      lane_rd    <= '0;
      lane_rs1   <= '0;
      lane_rs2   <= '0;
    end else if (state == IDLE && vec_issue) begin
      lane_aluop <= control_signals[3:0];
      lane_rd    <= rd;
      lane_rs1   <= rs1;
      lane_rs2   <= rs2;
    end
  end

  // A flush landing on the DONE cycle cancels both the pulse and the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_ops_count <= '0;
    end else if (state == DONE && !flush && vec_ops_count != '1) begin
      vec_ops_count <= vec_ops_count + CNT_W'(1);
    end
  end

  assign busy        = (state != IDLE);
  assign issue_ready = (state == IDLE);
  assign lane_valid  = (state == RUN);
  assign lane_idx    = idx;
  assign done        = (state == DONE) & ~flush;
  assign stall       = busy | vec_issue;

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Self-checking bench for vector_op_sequencer: element-count reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_vector_op_sequencer;
  localparam int VLEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        flush = 1'b0;
  logic        lane_ready = 1'b1;
  logic [15:0] control_signals = '0;
  logic [3:0]  rd = '0, rs1 = '0, rs2 = '0;

  logic        issue_ready, stall, lane_valid, busy, done;
  logic [2:0]  lane_idx;
  logic [3:0]  lane_aluop, lane_rd, lane_rs1, lane_rs2;
  logic [15:0] vec_ops_count;

  // Narrow-counter instance sharing all inputs, used to reach saturation quickly.
  logic [1:0]  sat_count;
  logic        sat_done;
  logic        s_unused_ir, s_unused_st, s_unused_lv, s_unused_busy;
  logic [2:0]  s_unused_idx;
  logic [3:0]  s_unused_op, s_unused_rd, s_unused_rs1, s_unused_rs2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;
  int last_done_cyc = -1;
  int done_pulses = 0;

  // Reference model state: op active flag, number of elements handshaken so far.
  bit         m_act = 1'b0;
  int         m_k = 0;
  int         m_idx = 0;
  logic [3:0] m_op = '0, m_rd = '0, m_rs1 = '0, m_rs2 = '0;
  int         m_cnt = 0;
  int         m_sat = 0;

  vector_op_sequencer #(.VLEN(8), .IDX_W(3), .REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .control_signals(control_signals),
    .rd(rd), .rs1(rs1), .rs2(rs2), .flush(flush), .issue_ready(issue_ready),
    .stall(stall), .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_idx(lane_idx),
    .lane_aluop(lane_aluop), .lane_rd(lane_rd), .lane_rs1(lane_rs1), .lane_rs2(lane_rs2),
    .busy(busy), .done(done), .vec_ops_count(vec_ops_count)
  );

  vector_op_sequencer #(.VLEN(8), .IDX_W(3), .REG_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .control_signals(control_signals),
    .rd(rd), .rs1(rs1), .rs2(rs2), .flush(flush), .issue_ready(s_unused_ir),
    .stall(s_unused_st), .lane_valid(s_unused_lv), .lane_ready(lane_ready),
    .lane_idx(s_unused_idx), .lane_aluop(s_unused_op), .lane_rd(s_unused_rd),
    .lane_rs1(s_unused_rs1), .lane_rs2(s_unused_rs2), .busy(s_unused_busy),
    .done(sat_done), .vec_ops_count(sat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic monitor();
    bit vec, e_lv, e_done;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act = 1'b0; m_k = 0; m_idx = 0; m_cnt = 0; m_sat = 0;
        continue;
      end
      vec    = issue_valid && control_signals[9] && !flush;
      e_lv   = m_act && (m_k < VLEN);
      e_done = m_act && (m_k == VLEN) && !flush;
      chk("m_lane_valid", lane_valid, e_lv);
      chk("m_busy", busy, m_act);
      chk("m_issue_ready", issue_ready, !m_act);
      chk("m_stall", stall, m_act || vec);
      chk("m_done", done, e_done);
      chk("m_count", vec_ops_count, m_cnt);
      chk("m_sat_done", sat_done, e_done);
      chk("m_sat_count", sat_count, m_sat);
      if (e_lv) begin
        chk("m_lane_idx", lane_idx, m_idx);
        chk("m_lane_aluop", lane_aluop, m_op);
        chk("m_lane_rd", lane_rd, m_rd);
        chk("m_lane_rs1", lane_rs1, m_rs1);
        chk("m_lane_rs2", lane_rs2, m_rs2);
      end
      if (done) begin
        done_pulses++;
        last_done_cyc = cyc;
      end
      if (!m_act) begin
        if (vec) begin
          m_act = 1'b1; m_k = 0; m_idx = 0;
          m_op = control_signals[3:0]; m_rd = rd; m_rs1 = rs1; m_rs2 = rs2;
        end
      end else if (flush) begin
        m_act = 1'b0; m_idx = 0;
      end else if (m_k < VLEN) begin
        if (lane_ready) begin
          m_k++;
          if (m_k < VLEN) m_idx = m_k;
        end
      end else begin
        m_act = 1'b0;
        if (m_cnt < 16'hFFFF) m_cnt++;
        if (m_sat < 3) m_sat++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int n);
    while (cyc - c0 < n) step();
  endtask

  task automatic issue(input logic [15:0] c, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2);
    control_signals = c; rd = d; rs1 = s1; rs2 = s2;
    issue_valid = 1'b1;
    c0 = cyc;
    step();
    issue_valid = 1'b0;
  endtask

  initial begin
    int base;
    fork
      monitor();
    join_none

    #2 rst = 1'b1;
    #1;
    chk("rst_lane_valid", lane_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_count", vec_ops_count, 16'h0);
    step(); step();
    rst = 1'b0;
    step();

    // Basic sequencing
    issue(16'h0201, 4'd3, 4'd1, 4'd2);
    step_to(2);
    chk("basic_idx", lane_idx, 3'd1);
    chk("basic_aluop", lane_aluop, 4'd1);
    chk("basic_rd", lane_rd, 4'd3);
    chk("basic_rs1", lane_rs1, 4'd1);
    chk("basic_rs2", lane_rs2, 4'd2);
    step_to(11);
    chk("basic_done_cycle", last_done_cyc - c0, 9);
    chk("basic_count", vec_ops_count, 16'd1);

    // Backpressure on cycles 3..5
    issue(16'h0201, 4'd3, 4'd1, 4'd2);
    while (cyc - c0 < 14) begin
      lane_ready = !((cyc - c0 >= 3) && (cyc - c0 <= 5));
      if (cyc - c0 == 5) chk("bp_idx_held", lane_idx, 3'd2);
      step();
    end
    lane_ready = 1'b1;
    chk("bp_done_cycle", last_done_cyc - c0, 12);
    chk("bp_count", vec_ops_count, 16'd2);

    // Scalar pass-through
    control_signals = 16'h0101; issue_valid = 1'b1;
    #1;
    chk("scalar_stall", stall, 1'b0);
    chk("scalar_ready", issue_ready, 1'b1);
    step(); step(); step();
    issue_valid = 1'b0;
    chk("scalar_count", vec_ops_count, 16'd2);

    // Flush at lane_idx 4, then restart
    issue(16'h0201, 4'd3, 4'd1, 4'd2);
    step_to(5);
    chk("flush_idx", lane_idx, 3'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_lv", lane_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    step(); step();
    chk("flush_count", vec_ops_count, 16'd2);
    issue(16'h0205, 4'd7, 4'd5, 4'd6);
    chk("restart_idx", lane_idx, 3'd0);
    step_to(11);
    chk("restart_count", vec_ops_count, 16'd3);

    // Flush coinciding with the last element handshake
    issue(16'h0202, 4'd1, 4'd2, 4'd3);
    step_to(8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_last_busy", busy, 1'b0);
    step();
    chk("flush_last_count", vec_ops_count, 16'd3);

    // Flush during the DONE cycle
    issue(16'h0203, 4'd4, 4'd5, 4'd6);
    step_to(9);
    chk("pre_flush_done", done, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_done_suppressed", done, 1'b0);
    step();
    flush = 1'b0;
    step();
    chk("flush_done_count", vec_ops_count, 16'd3);

    // Flush in IDLE blocks acceptance
    control_signals = 16'h0201; issue_valid = 1'b1; flush = 1'b1;
    step();
    issue_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", busy, 1'b0);

    // Async reset mid-RUN, between edges
    issue(16'h0201, 4'd3, 4'd1, 4'd2);
    step_to(4);
    #3 rst = 1'b1;
    #1;
    chk("arst_lane_valid", lane_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_stall", stall, 1'b0);
    chk("arst_ready", issue_ready, 1'b1);
    chk("arst_count", vec_ops_count, 16'd0);
    step();
    rst = 1'b0;
    step();

    // Back-to-back ops with issue held; also drives the narrow counter to saturation
    base = done_pulses;
    control_signals = 16'h0204; rd = 4'd9; rs1 = 4'd10; rs2 = 4'd11;
    issue_valid = 1'b1;
    c0 = cyc;
    repeat (49) step();
    issue_valid = 1'b0;
    step(); step();
    chk("b2b_done_pulses", done_pulses - base, 5);
    chk("b2b_last_done", last_done_cyc - c0, 49);
    chk("b2b_count", vec_ops_count, 16'd5);
    chk("sat_count", sat_count, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_op_sequencer.md
Name: vector_op_sequencer

Overview:
- Sequences vector instructions (decoded vector_wre = 1, e.g. add.V) over VLEN element lanes of the shared scalar-width ALU.
- Sits between decode and execute. Latches the decoded control word and register indices, stalls fetch/decode, and issues one element op per accepted handshake.
- Pulses done on completion and keeps a saturating count of completed vector ops.
- Scalar instructions pass through untouched; the sequencer ignores them.

Parameters:
- VLEN, 8, elements per vector register (power of two, >= 2)
- IDX_W, 3, lane index width = $clog2(VLEN)
- REG_W, 4, register index width
- CNT_W, 16, completed-op counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- issue_valid  in  1  decode presents a valid instruction
- control_signals  in  16  decoder control word: bit 9 = vector_wre, bits 3:0 = aluOp
- rd, rs1, rs2  in  REG_W each  vector register indices of the instruction
- flush  in  1  abort in-flight vector op (taken branch)
- issue_ready  out  1  sequencer can accept a vector instruction
- stall  out  1  freeze fetch/decode
- lane_valid  out  1  element op valid to ALU
- lane_ready  in  1  ALU accepts element op
- lane_idx  out  IDX_W  current element index
- lane_aluop  out  4  latched aluOp
- lane_rd, lane_rs1, lane_rs2  out  REG_W each  latched register indices
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, vector op completed
- vec_ops_count  out  CNT_W  completed vector ops, saturating

Behaviour:
- **Clock and reset:** clk is the single clock; rst is asynchronous, active-high.
- **Reset values:**
  - Reset forces state IDLE, idx = 0, and all latched fields = 0.
  - lane_valid, stall, busy, done = 0; vec_ops_count = 0.
  - issue_ready = 1 (IDLE).
  - Reset mid-operation aborts immediately with no done pulse.
- **State encoding:** IDLE, RUN, DONE (registered).
- **Accept condition:** vec_issue = issue_valid & control_signals[9] & ~flush.
- **IDLE:**
  - issue_ready = 1.
  - On vec_issue: latch aluOp, rd, rs1, rs2; set idx = 0; go to RUN.
  - Non-vector or invalid issue: stay in IDLE, no effect.
- **RUN:**
  - lane_valid = 1; lane_idx = idx.
  - On lane_valid & lane_ready: if idx == VLEN-1, go to DONE; else idx <= idx+1.
  - While lane_valid & ~lane_ready, all lane_* outputs are held stable.
- **DONE:**
  - done = 1 for exactly one cycle; vec_ops_count increments unless it is all-ones (saturates).
  - Next state is IDLE.
- **stall:** stall = busy | vec_issue (combinational).
  - The decode stage is frozen in the issue cycle and on every cycle until the sequencer returns to IDLE.
- **issue_ready** = (state == IDLE). It is 0 in RUN and DONE.
- **lane_* outputs:** lane_aluop and lane_rd/rs1/rs2 are registered, valid only when lane_valid = 1; they retain their last value otherwise.
- **Latency:** with lane_ready tied 1, issue in cycle 0 (IDLE) gives:
  - RUN for cycles 1..VLEN, DONE in cycle VLEN+1, IDLE in cycle VLEN+2.
  - stall high for cycles 0..VLEN+1.
  - Each low cycle of lane_ready adds one cycle.
- **flush:**
  - In RUN or DONE: next state IDLE, idx cleared, lane_valid drops next cycle.
  - No done pulse and no count increment, even if the last element handshake occurs in the same cycle.
  - In IDLE: blocks acceptance that cycle.
- **Boundary conditions:**
  - idx never exceeds VLEN-1 and does not wrap inside an op.
  - Back-to-back vector ops: the second is accepted no earlier than the IDLE cycle following DONE.
  - issue_valid with vector bit while busy is ignored; decode holds the instruction via stall.

Test Plan:
- **Basic sequencing:** VLEN = 8, lane_ready = 1, issue add.V (control_signals = 16'h0201, rd = 3, rs1 = 1, rs2 = 2) → lane_idx 0..7 on cycles 1..8 with lane_aluop = 1, lane_rd = 3; done pulses in cycle 9; stall high cycles 0..9; vec_ops_count = 1.
- **Backpressure:** lane_ready low on cycles 3–5 → lane_idx = 2 and all lane fields stable for those cycles; done moves to cycle 12.
- **Scalar pass-through:** issue_valid with control_signals = 16'h0101 (scalar add) → stall = 0, issue_ready stays 1, no lane_valid, count unchanged.
- **Flush:** flush asserted while lane_idx = 4 → IDLE next cycle, lane_valid = 0, no done pulse, count unchanged; next add.V restarts at idx 0.
- **Async reset:** rst pulse mid-RUN between clock edges → outputs reach reset values immediately, before the next edge.
- **Saturation:** preload the counter (force vec_ops_count to 16'hFFFE), run 3 vector ops → count reads FFFF, FFFF, FFFF; done pulses all 3 times.
